// File: rtl/sc_scbc_reg_pkg.sv
// Shared types for the SCBC register master: FSM state encoding and the response record.
package sc_scbc_reg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WSTB,
        RSTB,
        RWAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic [31:0] rdat;
        logic        err;
    } rsp_t;

endpackage

// File: rtl/sc_scbc_regmst.sv
// SCBC register master: executes one write, read or read-poll command per handshake.
// Read-poll is built only when SC_SCBC_REGMST_POLL_EN is defined; otherwise polls run as single reads.
module sc_scbc_regmst
    import sc_scbc_reg_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int RD_LAT     = 1,
    parameter int POLL_MAX   = 1000
) (
    input  logic                  SYSCLK,
    input  logic                  SYSRST,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_WR,
    input  logic                  CMD_POLL,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [31:0]           CMD_WDAT,
    input  logic [3:0]            CMD_WBEN,
    input  logic [31:0]           CMD_MASK,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [31:0]           RSP_RDAT,
    output logic                  RSP_ERR,
    output logic                  WENB,
    output logic [ADDR_WIDTH-1:0] WADR,
    output logic [31:0]           WDAT,
    output logic [3:0]            WBEN,
    output logic                  RENB,
    output logic [ADDR_WIDTH-1:0] RADR,
    input  logic [31:0]           RDAT,
    output logic                  BUSY
);

    localparam int CW = $clog2(RD_LAT + 1);

    state_t                r_state;
    state_t                w_next;
    rsp_t                  r_rsp;
    logic [CW-1:0]         r_cnt;
    logic [ADDR_WIDTH-1:0] r_wadr;
    logic [ADDR_WIDTH-1:0] r_radr;
    logic [31:0]           r_wdat;
    logic [3:0]            r_wben;
    logic                  w_accept;
    logic                  w_retry;
    logic                  w_err;

    assign w_accept = (r_state == IDLE) && CMD_VALID && !SYSRST;

`ifdef SC_SCBC_REGMST_POLL_EN
    localparam int PMAX = (POLL_MAX < 1) ? 1 : POLL_MAX;

    logic        r_poll;
    logic [31:0] r_exp;
    logic [31:0] r_mask;
    logic [15:0] r_att;
    logic        w_match;
    logic        w_last;

    assign w_match = ((RDAT ^ r_exp) & r_mask) == 32'd0;
    assign w_last  = ({16'd0, r_att} + 32'd1) >= 32'(PMAX);
    assign w_retry = r_poll && !w_match && !w_last;
    assign w_err   = r_poll && !w_match;

    // A write never polls, even if CMD_POLL is set alongside CMD_WR.
    always_ff @(posedge SYSCLK) begin
        if (SYSRST) begin
            r_poll <= 1'b0;
            r_exp  <= '0;
            r_mask <= '0;
            r_att  <= '0;
        end else if (w_accept) begin
            r_poll <= CMD_POLL && !CMD_WR;
            r_exp  <= CMD_WDAT;
            r_mask <= CMD_MASK;
            r_att  <= '0;
        end else if ((r_state == RWAIT) && (r_cnt == '0) && w_retry) begin
            r_att <= r_att + 16'd1;
        end
    end
`else
    logic w_unused;

    assign w_unused = ^{CMD_POLL, CMD_MASK};
    assign w_retry  = 1'b0;
    assign w_err    = 1'b0;
`endif

    always_ff @(posedge SYSCLK) begin
        if (SYSRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Bus payload registers only change at acceptance, so they hold between strobes.
    always_ff @(posedge SYSCLK) begin
        if (SYSRST) begin
            r_wadr <= '0;
            r_wdat <= '0;
            r_wben <= '0;
            r_radr <= '0;
            r_cnt  <= '0;
            r_rsp  <= '0;
        end else begin
            if (w_accept && CMD_WR) begin
                r_wadr <= CMD_ADDR;
                r_wdat <= CMD_WDAT;
                r_wben <= CMD_WBEN;
            end
            if (w_accept && !CMD_WR) begin
                r_radr <= CMD_ADDR;
            end
            if (r_state == WSTB) begin
                r_rsp <= '0;
            end
            if (r_state == RSTB) begin
                r_cnt <= CW'(RD_LAT - 1);
            end
            if (r_state == RWAIT) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CW'(1);
                end else begin
                    r_rsp.rdat <= RDAT;
                    r_rsp.err  <= w_err;
                end
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        CMD_READY = 1'b0;
        WENB      = 1'b0;
        RENB      = 1'b0;
        RSP_VALID = 1'b0;
        BUSY      = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                CMD_READY = !SYSRST;
                if (w_accept) begin
                    w_next = CMD_WR ? WSTB : RSTB;
                end
            end
            WSTB: begin
                WENB   = 1'b1;
                w_next = RESP;
            end
            RSTB: begin
                RENB   = 1'b1;
                w_next = RWAIT;
            end
            RWAIT: begin
                if (r_cnt == '0) begin
                    w_next = w_retry ? RSTB : RESP;
                end
            end
            RESP: begin
                RSP_VALID = 1'b1;
                if (RSP_READY) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign WADR     = r_wadr;
    assign WDAT     = r_wdat;
    assign WBEN     = r_wben;
    assign RADR     = r_radr;
    assign RSP_RDAT = r_rsp.rdat;
    assign RSP_ERR  = r_rsp.err;

endmodule

// File: tb/tb_sc_scbc_regmst.sv
// Self-checking bench for sc_scbc_regmst: directed and random commands against a per-command result model.
// Poll scenarios are exercised when SC_SCBC_REGMST_POLL_EN is defined.
module tb_sc_scbc_regmst;

    localparam int AW       = 32;
    localparam int RD_LAT   = 3;
    localparam int POLL_MAX = 4;

`ifdef SC_SCBC_REGMST_POLL_EN
    localparam bit POLL_ON = 1'b1;
`else
    localparam bit POLL_ON = 1'b0;
`endif

    logic          SYSCLK = 1'b0;
    logic          SYSRST;
    logic          CMD_VALID, CMD_READY, CMD_WR, CMD_POLL;
    logic [AW-1:0] CMD_ADDR;
    logic [31:0]   CMD_WDAT, CMD_MASK;
    logic [3:0]    CMD_WBEN;
    logic          RSP_VALID, RSP_READY, RSP_ERR;
    logic [31:0]   RSP_RDAT;
    logic          WENB, RENB, BUSY;
    logic [AW-1:0] WADR, RADR;
    logic [31:0]   WDAT, RDAT;
    logic [3:0]    WBEN;

    sc_scbc_regmst #(
        .ADDR_WIDTH(AW),
        .RD_LAT    (RD_LAT),
        .POLL_MAX  (POLL_MAX)
    ) dut (
        .SYSCLK   (SYSCLK),
        .SYSRST   (SYSRST),
        .CMD_VALID(CMD_VALID),
        .CMD_READY(CMD_READY),
        .CMD_WR   (CMD_WR),
        .CMD_POLL (CMD_POLL),
        .CMD_ADDR (CMD_ADDR),
        .CMD_WDAT (CMD_WDAT),
        .CMD_WBEN (CMD_WBEN),
        .CMD_MASK (CMD_MASK),
        .RSP_VALID(RSP_VALID),
        .RSP_READY(RSP_READY),
        .RSP_RDAT (RSP_RDAT),
        .RSP_ERR  (RSP_ERR),
        .WENB     (WENB),
        .WADR     (WADR),
        .WDAT     (WDAT),
        .WBEN     (WBEN),
        .RENB     (RENB),
        .RADR     (RADR),
        .RDAT     (RDAT),
        .BUSY     (BUSY)
    );

    always #5 SYSCLK = ~SYSCLK;

    int cyc = 0;
    always @(posedge SYSCLK) cyc <= cyc + 1;

    int errCount   = 0;
    int checkCount = 0;

    // Bus monitor and register responder state
    int            wenbCnt = 0;
    int            renbCnt = 0;
    int            bothCnt = 0;
    int            radrBad = 0;
    int            firstStbCyc = -1;
    logic [AW-1:0] curAddr = '0;
    logic [AW-1:0] seenWadr = '0;
    logic [31:0]   seenWdat = '0;
    logic [3:0]    seenWben = '0;
    logic [31:0]   respQ[$];
    logic [31:0]   presetQ[$];
    logic          pendValid = 1'b0;
    int            pendCyc = 0;
    logic [31:0]   pendData = '0;

    // Expected bus payload that must hold between strobes
    logic [AW-1:0] mWadr = '0;
    logic [31:0]   mWdat = '0;
    logic [3:0]    mWben = '0;
    logic [AW-1:0] mRadr = '0;

    // Responder: read data is valid only in the cycle exactly RD_LAT after RENB; junk otherwise.
    always @(negedge SYSCLK) begin
        if (pendValid && (pendCyc == cyc)) begin
            RDAT = pendData;
            pendValid = 1'b0;
        end else begin
            RDAT = $urandom;
        end
        if (WENB && RENB) bothCnt++;
        if (WENB) begin
            wenbCnt++;
            seenWadr = WADR;
            seenWdat = WDAT;
            seenWben = WBEN;
            if (firstStbCyc < 0) firstStbCyc = cyc;
        end
        if (RENB) begin
            renbCnt++;
            if (RADR != curAddr) radrBad++;
            if (firstStbCyc < 0) firstStbCyc = cyc;
            pendValid = 1'b1;
            pendCyc   = cyc + RD_LAT;
            pendData  = (respQ.size() > 0) ? respQ.pop_front() : $urandom;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, " WENB"}, 64'(WENB), 64'(0));
        checkOutput({tag, " RENB"}, 64'(RENB), 64'(0));
        checkOutput({tag, " RSP_VALID"}, 64'(RSP_VALID), 64'(0));
        checkOutput({tag, " RSP_RDAT"}, 64'(RSP_RDAT), 64'(0));
        checkOutput({tag, " RSP_ERR"}, 64'(RSP_ERR), 64'(0));
        checkOutput({tag, " BUSY"}, 64'(BUSY), 64'(0));
        checkOutput({tag, " WADR"}, 64'(WADR), 64'(0));
        checkOutput({tag, " WDAT"}, 64'(WDAT), 64'(0));
        checkOutput({tag, " WBEN"}, 64'(WBEN), 64'(0));
        checkOutput({tag, " RADR"}, 64'(RADR), 64'(0));
        checkOutput({tag, " CMD_READY"}, 64'(CMD_READY), 64'(0));
    endtask

    // Issues one command (entered and left at #1 after a negedge) and checks its whole transaction.
    task automatic applyStimulus(input logic wr, input logic poll, input logic [AW-1:0] addr,
                                 input logic [31:0] wdat, input logic [3:0] wben,
                                 input logic [31:0] mask, input int readyDelay);
        logic [31:0] vals[$];
        logic [31:0] v;
        logic [31:0] expRdat;
        logic        expErr;
        bit          doPoll;
        int          expReads, expLat, w0, r0, rb0, t0, rspCyc, waitCnt;
        doPoll = POLL_ON && poll && !wr;
        if (presetQ.size() > 0) begin
            vals = presetQ;
            presetQ.delete();
        end else if (!wr) begin
            for (int i = 0; i < (doPoll ? POLL_MAX : 1); i++) begin
                v = $urandom;
                if ($urandom_range(0, 2) == 0) v = (v & ~mask) | (wdat & mask);
                vals.push_back(v);
            end
        end
        expRdat  = '0;
        expErr   = 1'b0;
        expReads = 0;
        expLat   = 2;
        if (!wr) begin
            if (doPoll) begin
                expErr = 1'b1;
                for (int i = 0; i < vals.size(); i++) begin
                    if (expErr) begin
                        expReads = i + 1;
                        expRdat  = vals[i];
                        if ((vals[i] & mask) == (wdat & mask)) expErr = 1'b0;
                    end
                end
            end else begin
                expReads = 1;
                expRdat  = vals[0];
            end
            expLat = 1 + expReads * (1 + RD_LAT);
        end
        respQ       = vals;
        curAddr     = addr;
        w0          = wenbCnt;
        r0          = renbCnt;
        rb0         = radrBad;
        firstStbCyc = -1;

        checkOutput("cmd ready in idle", 64'(CMD_READY), 64'(1));
        CMD_VALID = 1'b1;
        CMD_WR    = wr;
        CMD_POLL  = poll;
        CMD_ADDR  = addr;
        CMD_WDAT  = wdat;
        CMD_WBEN  = wben;
        CMD_MASK  = mask;
        RSP_READY = (readyDelay == 0);
        t0 = cyc;
        @(negedge SYSCLK); #1;
        checkOutput("busy after accept", 64'(BUSY), 64'(1));
        checkOutput("cmd ready while busy", 64'(CMD_READY), 64'(0));
        rspCyc  = -1;
        waitCnt = 0;
        while ((rspCyc < 0) && (waitCnt < 200)) begin
            if (RSP_VALID) begin
                rspCyc = cyc;
            end else begin
                CMD_VALID = 1'($urandom);
                CMD_WR    = 1'($urandom);
                CMD_POLL  = 1'($urandom);
                CMD_ADDR  = $urandom;
                CMD_WDAT  = $urandom;
                CMD_WBEN  = 4'($urandom);
                CMD_MASK  = $urandom;
                @(negedge SYSCLK); #1;
                waitCnt++;
            end
        end
        CMD_VALID = 1'b0;
        if (rspCyc < 0) begin
            checkOutput("response timeout", 64'(0), 64'(1));
            RSP_READY = 1'b0;
            return;
        end
        checkOutput("rsp latency", 64'(rspCyc - t0), 64'(expLat));
        checkOutput("rsp rdat", 64'(RSP_RDAT), 64'(expRdat));
        checkOutput("rsp err", 64'(RSP_ERR), 64'(expErr));
        checkOutput("wenb pulses", 64'(wenbCnt - w0), 64'(wr ? 1 : 0));
        checkOutput("renb pulses", 64'(renbCnt - r0), 64'(expReads));
        checkOutput("first strobe cycle", 64'(firstStbCyc - t0), 64'(1));
        checkOutput("radr at renb", 64'(radrBad - rb0), 64'(0));
        if (wr) begin
            checkOutput("wadr at wenb", 64'(seenWadr), 64'(addr));
            checkOutput("wdat at wenb", 64'(seenWdat), 64'(wdat));
            checkOutput("wben at wenb", 64'(seenWben), 64'(wben));
        end
        for (int i = 0; i < readyDelay; i++) begin
            @(negedge SYSCLK); #1;
            checkOutput("rsp valid held", 64'(RSP_VALID), 64'(1));
            checkOutput("rsp rdat held", 64'(RSP_RDAT), 64'(expRdat));
            checkOutput("rsp err held", 64'(RSP_ERR), 64'(expErr));
            checkOutput("cmd ready during resp", 64'(CMD_READY), 64'(0));
        end
        RSP_READY = 1'b1;
        @(negedge SYSCLK); #1;
        RSP_READY = 1'b0;
        checkOutput("rsp valid after handshake", 64'(RSP_VALID), 64'(0));
        checkOutput("cmd ready after handshake", 64'(CMD_READY), 64'(1));
        if (wr) begin
            mWadr = addr;
            mWdat = wdat;
            mWben = wben;
        end else begin
            mRadr = addr;
        end
        checkOutput("wadr hold", 64'(WADR), 64'(mWadr));
        checkOutput("wdat hold", 64'(WDAT), 64'(mWdat));
        checkOutput("wben hold", 64'(WBEN), 64'(mWben));
        checkOutput("radr hold", 64'(RADR), 64'(mRadr));
    endtask

    // Asserts reset while a read sits in RWAIT; the command must vanish without a response.
    task automatic applyResetMidRead(input logic [AW-1:0] addr);
        int r0, w0;
        respQ.delete();
        respQ.push_back(32'h1234_5678);
        curAddr   = addr;
        CMD_VALID = 1'b1;
        CMD_WR    = 1'b0;
        CMD_POLL  = 1'b0;
        CMD_ADDR  = addr;
        RSP_READY = 1'b1;
        @(negedge SYSCLK); #1;
        CMD_VALID = 1'b0;
        checkOutput("rst test renb", 64'(RENB), 64'(1));
        @(negedge SYSCLK); #1;
        checkOutput("rst test busy in rwait", 64'(BUSY), 64'(1));
        SYSRST = 1'b1;
        @(negedge SYSCLK); #1;
        checkIdleZero("reset in rwait");
        SYSRST = 1'b0;
        r0 = renbCnt;
        w0 = wenbCnt;
        mWadr = '0;
        mWdat = '0;
        mWben = '0;
        mRadr = '0;
        @(negedge SYSCLK); #1;
        checkOutput("cmd ready after reset", 64'(CMD_READY), 64'(1));
        for (int i = 0; i < RD_LAT + 3; i++) begin
            checkOutput("no rsp after reset", 64'(RSP_VALID), 64'(0));
            if (i < RD_LAT + 2) begin
                @(negedge SYSCLK); #1;
            end
        end
        checkOutput("no renb after reset", 64'(renbCnt - r0), 64'(0));
        checkOutput("no wenb after reset", 64'(wenbCnt - w0), 64'(0));
        RSP_READY = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] v;
        SYSRST    = 1'b1;
        CMD_VALID = 1'b0;
        CMD_WR    = 1'b0;
        CMD_POLL  = 1'b0;
        CMD_ADDR  = '0;
        CMD_WDAT  = '0;
        CMD_WBEN  = '0;
        CMD_MASK  = '0;
        RSP_READY = 1'b0;
        repeat (3) @(negedge SYSCLK);
        #1;
        checkIdleZero("during reset");
        SYSRST = 1'b0;
        @(negedge SYSCLK); #1;
        checkOutput("cmd ready after reset release", 64'(CMD_READY), 64'(1));
        checkOutput("busy after reset release", 64'(BUSY), 64'(0));

        $display("[TB] directed write and read");
        applyStimulus(1'b1, 1'b0, 32'h04, 32'hDEAD_BEEF, 4'hF, 32'h0, 0);
        presetQ.push_back(32'h0001_0200);
        applyStimulus(1'b0, 1'b0, 32'h00, 32'h0, 4'h0, 32'h0, 0);

        $display("[TB] response backpressure then back-to-back command");
        applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 5);
        applyStimulus(1'b1, 1'b0, 32'h14, 32'h5A5A_0F0F, 4'h3, 32'h0, 0);

`ifdef SC_SCBC_REGMST_POLL_EN
        $display("[TB] poll scenarios");
        presetQ.push_back(32'hA0A0_0000);
        presetQ.push_back(32'h0000_0010);
        presetQ.push_back(32'h0000_0011);
        applyStimulus(1'b0, 1'b1, 32'h20, 32'h1, 4'h0, 32'h1, 0);
        for (int i = 0; i < POLL_MAX; i++) begin
            v = $urandom;
            presetQ.push_back(v & 32'hFFFF_FFFE);
        end
        applyStimulus(1'b0, 1'b1, 32'h24, 32'h1, 4'h0, 32'h1, 1);
`else
        $display("[TB] poll request without poll support");
        presetQ.push_back(32'h0000_0000);
        applyStimulus(1'b0, 1'b1, 32'h20, 32'h1, 4'h0, 32'h1, 0);
`endif

        $display("[TB] write with poll flag set");
        applyStimulus(1'b1, 1'b1, 32'h28, 32'hCAFE_F00D, 4'hC, 32'hFFFF_FFFF, 0);

        $display("[TB] randomized commands");
        for (int n = 0; n < 30; n++) begin
            applyStimulus(1'($urandom), 1'($urandom), $urandom & 32'h0000_00FC, $urandom,
                          4'($urandom), 32'h1 << $urandom_range(0, 7), int'($urandom_range(0, 3)));
        end

        $display("[TB] reset during read wait");
        applyResetMidRead(32'h30);
        applyStimulus(1'b1, 1'b0, 32'h34, 32'h1357_9BDF, 4'h5, 32'h0, 1);
        applyStimulus(1'b0, 1'b0, 32'h38, 32'h0, 4'h0, 32'h0, 2);

        checkOutput("wenb and renb never together", 64'(bothCnt), 64'(0));
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
